spi_window_receiver: RTL and testbench
======================================

Name: spi_window_receiver

Overview:
- Parametrised successor to the SPI pixel front end: receives fixed-length SPI words carrying multi-channel pixels and maintains a per-channel horizontal sliding window of the last WIN pixels in spatial order.
- Tracks raster coordinates and presents each updated window on a valid/ready handshake to the edge-detection datapath.
- Runs entirely in the mainClk domain: SPI pins are oversampled and synchronised internally, so there is no second clock domain.

Parameters:
- MSG_BITS, 16, SPI word length in bits, MSB first.
- PIXEL_BITS, 4, bits per channel sample.
- CHANNELS, 3, samples per word. Channel 0 is in the most-significant payload bits; the payload is word[CHANNELS*PIXEL_BITS-1:0]. Elaboration error if CHANNELS*PIXEL_BITS > MSG_BITS.
- WIN, 3, window width in pixels; must be >= 1.
- IMG_WIDTH, 320, pixels per row.
- IMG_HEIGHT, 240, rows per frame.

Ports:
- mainClk  in  1  system clock; must be >= 4x the SPI clock rate.
- nreset  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock, asynchronous to mainClk; mode 0.
- sdi  in  1  SPI data.
- ncs  in  1  SPI chip select, active low.
- clearCoords  in  1  synchronous pulse; next word is treated as (0,0).
- outReady  in  1  downstream accepts the window.
- pixelWindow  out  CHANNELS*WIN*PIXEL_BITS  sample [c][s] at bit offset (c*WIN+s)*PIXEL_BITS; slot 0 is oldest/leftmost, slot WIN-1 is newest.
- windowValid  out  1  window holds an unconsumed update.
- windowFull  out  1  all WIN slots belong to the current row.
- xVal  out  $clog2(IMG_WIDTH)  x of the newest pixel.
- yVal  out  $clog2(IMG_HEIGHT)  y of the newest pixel.
- frameDone  out  1  high with the valid for pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
- overflow  out  1  sticky: a word arrived while the previous window was unaccepted.

Behaviour:
- Reset (async):
  - All outputs 0; window zeroed.
  - Shift register, bit counter and internal next-coordinate (0,0) cleared.
  - Synchronisers are set to idle (ncs=1, sclk=0).
- Input sync:
  - Two-flop synchroniser on each of sclk, sdi and ncs.
  - Edges are detected from the synced sclk against its previous value.
- Receive FSM:
  - IDLE: entered on synced ncs high. Bit counter is 0.
  - SHIFT: entered on synced ncs low. On each synced sclk rising edge, shift synced sdi into the LSB and increment the counter.
  - When the counter reaches MSG_BITS, assert internal wordDone for one cycle, reset the counter to 0, and stay in SHIFT so back-to-back words need no ncs toggle.
  - ncs rising with a partial count: the partial word is discarded, no wordDone, the counter is cleared.
  - Falling sclk edges are ignored.
- Word accept (the cycle after wordDone, i.e. 1 mainClk of latency):
  - If the next-x is 0, slots 0..WIN-2 are cleared to 0 and the payload is written to slot WIN-1.
  - Otherwise the window shifts one slot toward slot 0 (the oldest slot drops) and the payload enters slot WIN-1.
  - xVal/yVal take the next-coordinate; next-coordinate advances.
  - Next-x wraps to 0 after IMG_WIDTH-1 and increments y; y wraps to 0 after IMG_HEIGHT-1. There is no overshoot: coordinate sequences are exact.
  - windowValid is set. windowFull = (new xVal >= WIN-1).
  - frameDone = (new xVal, yVal) == (IMG_WIDTH-1, IMG_HEIGHT-1). It is held exactly as long as windowValid is held for that pixel.
- Handshake:
  - windowValid clears on a cycle where windowValid && outReady and no accept happens in that cycle.
  - pixelWindow, xVal and yVal are stable while windowValid is high and unaccepted.
- Overflow:
  - An accept while windowValid && !outReady still updates the window (newest data wins) and sets overflow.
  - Accept and handshake in the same cycle: the old window is consumed, the new one loads, windowValid stays 1, no overflow.
  - overflow clears only on reset.
- clearCoords:
  - Sets next-coordinate to (0,0); the following accept starts a new row and frame.
  - It does not alter the current outputs or windowValid.
  - If it coincides with an accept, that accepted word is placed at (0,0).
- WIN=1: no shift; the window is always the newest pixel and windowFull is always 1.

Test Plan:
- Reset mid-word (8 of 16 bits clocked), then a full word 0x0ABC -> after release no valid is produced for the partial word; the next word gives slot2 ch0=0xA, ch1=0xB, ch2=0xC, xVal=0, windowFull=0, windowValid high 1 cycle after wordDone.
- Three words 0x0123, 0x0456, 0x0789 with outReady=1 -> after the third: ch0 slots[0..2]=1,4,7; ch2=3,6,9; xVal=2; windowFull=1.
- Stream 320 words -> xVal runs 0..319 then the 321st word has xVal=0, yVal=1, slots 0..1 zeroed, windowFull=0.
- Stream 320*240 words -> frameDone high only with (319,239); the next word is (0,0).
- outReady=0 across two words -> overflow=1, window shows the second word; then outReady=1 -> windowValid drops next cycle, overflow stays 1.
- ncs raised after 10 bits, then lowered and 16 bits sent; clearCoords pulsed mid-row -> no spurious valid; the next accepted word is at (0,0) with slots 0..1 zeroed.

Source files
------------

// File: rtl/spi_window_receiver.sv
// ----------------------------------------------------------------------------
// spi_window_receiver
//   Receives fixed-length SPI words (mode 0, MSB first) carrying CHANNELS
//   pixel samples and keeps a per-channel horizontal sliding window of the
//   last WIN pixels of the current row. Each updated window is offered on a
//   valid/ready handshake together with its raster coordinates. The SPI pins
//   are oversampled in the mainClk domain (mainClk >= 4x sclk).
//
// Ports
//   mainClk, nreset        system clock, async active-low reset
//   sclk, sdi, ncs         raw SPI pins (asynchronous to mainClk)
//   clearCoords            pulse: next accepted word lands at (0,0)
//   outReady               downstream accepts the presented window
//   pixelWindow            sample [c][s] at bit (c*WIN+s)*PIXEL_BITS,
//                          slot 0 oldest, slot WIN-1 newest
//   windowValid            window holds an unconsumed update
//   windowFull             every slot belongs to the current row
//   xVal, yVal             coordinates of the newest pixel
//   frameDone              valid window is the last pixel of the frame
//   overflow               sticky: a word overwrote an unaccepted window
// ----------------------------------------------------------------------------
module spi_window_receiver #(
    parameter int MSG_BITS   = 16,
    parameter int PIXEL_BITS = 4,
    parameter int CHANNELS   = 3,
    parameter int WIN        = 3,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                                  mainClk,
    input  logic                                  nreset,
    input  logic                                  sclk,
    input  logic                                  sdi,
    input  logic                                  ncs,
    input  logic                                  clearCoords,
    input  logic                                  outReady,
    output logic [CHANNELS*WIN*PIXEL_BITS-1:0]    pixelWindow,
    output logic                                  windowValid,
    output logic                                  windowFull,
    output logic [$clog2(IMG_WIDTH)-1:0]          xVal,
    output logic [$clog2(IMG_HEIGHT)-1:0]         yVal,
    output logic                                  frameDone,
    output logic                                  overflow
);

    localparam int PB = PIXEL_BITS;
    localparam int PW = CHANNELS * WIN * PIXEL_BITS;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(MSG_BITS + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MSG_BITS - 1);

    if (CHANNELS * PIXEL_BITS > MSG_BITS) begin : g_bad_payload
        $error("spi_window_receiver: CHANNELS*PIXEL_BITS exceeds MSG_BITS");
    end
    if (WIN < 1) begin : g_bad_win
        $error("spi_window_receiver: WIN must be >= 1");
    end

    // ------------------------------------------------------------------
    // Pin synchronisers. Reset to the idle bus state so no edge or
    // chip-select is seen while coming out of reset.
    // ------------------------------------------------------------------
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic sdi_meta_q,  sdi_sync_q;
    logic ncs_meta_q,  ncs_sync_q;

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            ncs_meta_q  <= 1'b1;
            ncs_sync_q  <= 1'b1;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            sdi_meta_q  <= sdi;
            sdi_sync_q  <= sdi_meta_q;
            ncs_meta_q  <= ncs;
            ncs_sync_q  <= ncs_meta_q;
        end
    end

    logic sclk_rise;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    typedef enum logic {S_IDLE, S_SHIFT} rx_state_t;

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MSG_BITS-1:0]   shift_q, shift_d;
    logic                  word_done_q, word_done_d;

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d     = ncs_sync_q ? S_IDLE : S_SHIFT;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_done_d = 1'b0;
        case (state_q)
            S_IDLE: cnt_d = '0;
            S_SHIFT: begin
                if (ncs_sync_q) begin
                    // deselect mid-word: partial word is dropped
                    cnt_d = '0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[MSG_BITS-2:0], sdi_sync_q};
                    if (cnt_q == CNT_LAST) begin
                        // stay in SHIFT so words can stream back-to-back
                        cnt_d       = '0;
                        word_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Window / coordinate datapath. The completed word stays in shift_q
    // for the word_done_q cycle because the next sclk rise is at least
    // two mainClk cycles away.
    // ------------------------------------------------------------------
    logic [PW-1:0]  win_q, win_d, win_new;
    logic [XW-1:0]  x_q, x_d, nx_q, nx_d, ex;
    logic [YW-1:0]  y_q, y_d, ny_q, ny_d, ey;
    logic           valid_q, valid_d;
    logic           full_q, full_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    // clearCoords in the accept cycle already applies to that word
    assign ex = clearCoords ? '0 : nx_q;
    assign ey = clearCoords ? '0 : ny_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar s = 0; s < WIN; s++) begin : g_slot
            if (s == WIN - 1) begin : g_newest
                assign win_new[(c*WIN+s)*PB +: PB] = shift_q[(CHANNELS-1-c)*PB +: PB];
            end else begin : g_older
                // a new row starts with an empty history
                assign win_new[(c*WIN+s)*PB +: PB] =
                    (ex == '0) ? '0 : win_q[(c*WIN+s+1)*PB +: PB];
            end
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            win_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            x_q     <= x_d;
            y_q     <= y_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        win_d   = win_q;
        x_d     = x_q;
        y_d     = y_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        valid_d = valid_q;
        full_d  = full_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (word_done_q) begin
            win_d   = win_new;
            x_d     = ex;
            y_d     = ey;
            valid_d = 1'b1;
            full_d  = (32'(ex) >= 32'(WIN - 1));
            done_d  = (ex == X_LAST) && (ey == Y_LAST);
            if (ex == X_LAST) begin
                nx_d = '0;
                ny_d = (ey == Y_LAST) ? '0 : ey + 1'b1;
            end else begin
                nx_d = ex + 1'b1;
                ny_d = ey;
            end
            // a same-cycle handshake consumes the old window: no overflow
            if (valid_q && !outReady) begin
                ovf_d = 1'b1;
            end
        end else begin
            if (clearCoords) begin
                nx_d = '0;
                ny_d = '0;
            end
            if (valid_q && outReady) begin
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        end
    end

    assign pixelWindow = win_q;
    assign windowValid = valid_q;
    assign windowFull  = full_q;
    assign xVal        = x_q;
    assign yVal        = y_q;
    assign frameDone   = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_spi_window_receiver.sv
module tb_spi_window_receiver;

    // Small image so a whole frame streams within the cycle budget.
    localparam int W = 10;
    localparam int H = 4;

    logic        mainClk = 1'b0;
    logic        nreset, sclk, sdi, ncs, clearCoords, outReady;
    logic [35:0] pixelWindow;
    logic        windowValid, windowFull, frameDone, overflow;
    logic [3:0]  xVal;
    logic [1:0]  yVal;

    int n_chk  = 0;
    int n_fail = 0;

    spi_window_receiver #(
        .MSG_BITS(16), .PIXEL_BITS(4), .CHANNELS(3), .WIN(3),
        .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .mainClk(mainClk), .nreset(nreset), .sclk(sclk), .sdi(sdi), .ncs(ncs),
        .clearCoords(clearCoords), .outReady(outReady),
        .pixelWindow(pixelWindow), .windowValid(windowValid),
        .windowFull(windowFull), .xVal(xVal), .yVal(yVal),
        .frameDone(frameDone), .overflow(overflow)
    );

    always #5 mainClk = ~mainClk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] px(input int c, input int s);
        return pixelWindow[(c*3+s)*4 +: 4];
    endfunction

    // sclk half period = 3 mainClk cycles, all pin changes on negedge
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            sdi = w[i];
            repeat (3) @(negedge mainClk);
            sclk = 1'b1;
            repeat (3) @(negedge mainClk);
            sclk = 1'b0;
        end
    endtask

    // lat = negedge index (from the last sclk rise) where windowValid is
    // first seen, -1 if never; fd = frameDone sampled at that point.
    task automatic send_word(input logic [15:0] w, output int lat, output logic fd);
        lat = -1;
        fd  = 1'b0;
        send_bits(w, 15);
        sdi = w[0];
        repeat (3) @(negedge mainClk);
        sclk = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge mainClk);
            if (k == 2) sclk = 1'b0;
            if (lat < 0 && windowValid) begin
                lat = k;
                fd  = frameDone;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge mainClk);
        clearCoords = 1'b1;
        @(negedge mainClk);
        clearCoords = 1'b0;
    endtask

    initial begin
        int   lat;
        logic fd;
        nreset = 1'b0; sclk = 1'b0; sdi = 1'b0; ncs = 1'b1;
        clearCoords = 1'b0; outReady = 1'b1;
        repeat (3) @(negedge mainClk);

        // reset state
        chk("rst_valid", windowValid, 0);
        chk("rst_window", pixelWindow, 0);
        chk("rst_xy", {xVal, yVal}, 0);
        chk("rst_flags", {windowFull, frameDone, overflow}, 0);

        nreset = 1'b1;
        ncs    = 1'b0;
        repeat (5) @(negedge mainClk);

        // partial word cut by reset, then a clean word
        send_bits(16'hF0F0, 8);
        nreset = 1'b0;
        repeat (3) @(negedge mainClk);
        nreset = 1'b1;
        repeat (10) @(negedge mainClk);
        chk("partial_novalid", windowValid, 0);
        send_word(16'h0ABC, lat, fd);
        chk("w0_latency", lat, 3);
        chk("w0_slot2", {px(0,2), px(1,2), px(2,2)}, 12'hABC);
        chk("w0_old_slots", {px(0,0), px(0,1), px(2,1)}, 0);
        chk("w0_x", xVal, 0);
        chk("w0_full", windowFull, 0);
        chk("w0_valid_dropped", windowValid, 0);

        // three words at x=0,1,2
        pulse_clear();
        send_word(16'h0123, lat, fd);
        send_word(16'h0456, lat, fd);
        chk("w2_full", windowFull, 0);
        send_word(16'h0789, lat, fd);
        chk("w3_latency", lat, 3);
        chk("w3_ch0", {px(0,0), px(0,1), px(0,2)}, 12'h147);
        chk("w3_ch1", {px(1,0), px(1,1), px(1,2)}, 12'h258);
        chk("w3_ch2", {px(2,0), px(2,1), px(2,2)}, 12'h369);
        chk("w3_x", xVal, 2);
        chk("w3_full", windowFull, 1);

        // finish the row (x=3..9), then wrap
        for (int i = 3; i < W; i++) begin
            send_word(16'h0FFF, lat, fd);
            chk("row_x", {yVal, xVal}, {2'd0, 4'(i)});
        end
        send_word(16'h0ABC, lat, fd);
        chk("wrap_xy", {yVal, xVal}, {2'd1, 4'd0});
        chk("wrap_zeroed", {px(0,0), px(0,1), px(1,1), px(2,0)}, 0);
        chk("wrap_new", {px(0,2), px(2,2)}, 8'hAC);
        chk("wrap_full", windowFull, 0);

        // whole frame from (0,0)
        pulse_clear();
        for (int i = 0; i < W * H; i++) begin
            send_word(16'(i), lat, fd);
            chk("frame_lat", lat, 3);
            chk("frame_xy", {yVal, xVal}, {2'(i / W), 4'(i % W)});
            chk("frame_done", fd, (i == W * H - 1));
        end
        chk("frame_done_cleared", frameDone, 0);
        send_word(16'h0321, lat, fd);
        chk("frame_next_xy", {yVal, xVal}, 0);
        chk("frame_next_fd", fd, 0);

        // overflow: two words without outReady (x=1, x=2)
        outReady = 1'b0;
        send_word(16'h0111, lat, fd);
        repeat (5) @(negedge mainClk);
        chk("hold_valid", windowValid, 1);
        chk("hold_x", xVal, 1);
        chk("hold_ovf", overflow, 0);
        send_word(16'h0222, lat, fd);
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", windowValid, 1);
        chk("ovf_newest", {px(0,0), px(0,1), px(0,2)}, 12'h312);
        chk("ovf_x", xVal, 2);
        outReady = 1'b1;
        @(negedge mainClk);
        chk("ovf_consumed", windowValid, 0);
        chk("ovf_sticky", overflow, 1);

        // deselect after 10 bits, then clear mid-row and a full word
        send_bits(16'hFFFF, 10);
        ncs = 1'b1;
        repeat (8) @(negedge mainClk);
        chk("abort_novalid", windowValid, 0);
        ncs = 1'b0;
        repeat (5) @(negedge mainClk);
        pulse_clear();
        send_word(16'h0DEF, lat, fd);
        chk("abort_latency", lat, 3);
        chk("abort_xy", {yVal, xVal}, 0);
        chk("abort_zeroed", {px(0,0), px(0,1), px(1,0), px(2,1)}, 0);
        chk("abort_new", {px(0,2), px(1,2), px(2,2)}, 12'hDEF);
        chk("abort_ovf", overflow, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
